demux_router: RTL and testbench

- 1-to-NOUT datapath demultiplexer: the routing counterpart of the 2:1 operand select mux.
- Takes one stream of DATA_W-bit words, each tagged with a destination select, and delivers each word to exactly one of NOUT output channels.
- Both sides use valid/ready handshakes. A 2-entry skid buffer gives full throughput with a registered ready.
- Sits between the ALU result bus and the per-destination consumers (register-file write port, memory write buffer, I/O).

---
 rtl/demux_router.sv | 82 ++++++++
 tb/tb_demux_router.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_router.sv
// demux_router: routes a valid/ready word stream to one of NOUT channels through a 2-entry skid buffer
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data/in_sel input stream;
//        out_valid (one-hot per channel), out_ready, shared out_data;
//        xfer_count (wrapping output handshakes), drop_count (saturating out-of-range drops)
module demux_router #(
    parameter int DATA_W = 16,
    parameter int NOUT   = 4,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [NOUT-1:0]   out_valid,
    input  logic [NOUT-1:0]   out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       xfer_count,
    output logic [7:0]        drop_count
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t            state;
    logic [DATA_W-1:0] skid_data;
    logic [SEL_W-1:0]  skid_sel;
    logic              in_range, acc, drop, pop;
    // out_valid doubles as the head register's valid bit and its decoded select
    assign in_range = int'(in_sel) < NOUT;
    assign acc      = in_valid & in_ready & in_range;
    assign drop     = in_valid & in_ready & ~in_range;
    assign pop      = |(out_valid & out_ready);
    function automatic logic [NOUT-1:0] dec(input logic [SEL_W-1:0] s);
        return NOUT'(1) << s;
    endfunction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready   <= 1'b0;
            out_valid  <= '0;
            out_data   <= '0;
            skid_data  <= '0;
            skid_sel   <= '0;
            xfer_count <= '0;
            drop_count <= '0;
        end else begin
            xfer_count <= xfer_count + 16'(pop);
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            case (state)
                EMPTY: begin
                    in_ready <= 1'b1;
                    if (acc) begin
                        state     <= ONE;
                        out_valid <= dec(in_sel);
                        out_data  <= in_data;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        out_valid <= dec(in_sel);
                        out_data  <= in_data;
                    end else if (acc) begin
                        state     <= TWO;
                        skid_data <= in_data;
                        skid_sel  <= in_sel;
                        in_ready  <= 1'b0;
                    end else if (pop) begin
                        state     <= EMPTY;
                        out_valid <= '0;
                    end
                end
                default: begin
                    if (pop) begin
                        state     <= ONE;
                        out_valid <= dec(skid_sel);
                        out_data  <= skid_data;
                        in_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: random and directed checks of demux_router (NOUT=4 and NOUT=3) against a queue model
module tb_demux_router;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [1:0]  in_sel = '0;
    logic [3:0]  out_ready = '0;
    logic        rdy0, rdy1;
    logic [3:0]  ov0;
    logic [2:0]  ov1;
    logic [15:0] od0, od1, x0, x1;
    logic [7:0]  d0, d1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_router #(.DATA_W(16), .NOUT(4), .SEL_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_sel(in_sel), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .xfer_count(x0), .drop_count(d0));

    demux_router #(.DATA_W(16), .NOUT(3), .SEL_W(2)) u_drop (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_sel(in_sel), .out_valid(ov1), .out_ready(out_ready[2:0]),
        .out_data(od1), .xfer_count(x1), .drop_count(d1));

    // model: each instance is a FIFO of in-range words; the head is what is on the outputs
    typedef struct {logic [15:0] d; logic [1:0] s;} w_t;
    localparam int NO[2] = '{4, 3};
    w_t          q[2][$];
    logic        m_rdy[2] = '{1'b0, 1'b0};
    logic [15:0] m_x[2] = '{16'd0, 16'd0};
    logic [15:0] m_od[2] = '{16'd0, 16'd0};
    logic [7:0]  m_d[2] = '{8'd0, 8'd0};
    logic        acc_seen = 1'b0;

    task automatic clear();
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            m_rdy[k] = 1'b0;
            m_x[k] = '0;
            m_od[k] = '0;
            m_d[k] = '0;
        end
        acc_seen = 1'b0;
    endtask

    task automatic step();
        for (int k = 0; k < 2; k++) begin
            logic take, pop;
            w_t w;
            take = in_valid && m_rdy[k];
            pop = q[k].size() > 0 && out_ready[q[k][0].s];
            if (k == 0) acc_seen = take;
            if (pop) begin
                void'(q[k].pop_front());
                m_x[k] = m_x[k] + 16'd1;
            end
            if (take && int'(in_sel) < NO[k]) begin
                w.d = in_data;
                w.s = in_sel;
                q[k].push_back(w);
            end else if (take && m_d[k] != 8'hFF) m_d[k] = m_d[k] + 8'd1;
            if (q[k].size() > 0) m_od[k] = q[k][0].d;
            m_rdy[k] = q[k].size() < 2;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) clear();
        else step();
    end

    function automatic logic [63:0] exp_ov(input int k);
        return q[k].size() > 0 ? 64'(1) << q[k][0].s : 64'd0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("ov0", 64'(ov0), exp_ov(0));
        chk("ov1", 64'(ov1), exp_ov(1));
        chk("od0", 64'(od0), 64'(m_od[0]));
        chk("od1", 64'(od1), 64'(m_od[1]));
        chk("rdy0", 64'(rdy0), 64'(m_rdy[0]));
        chk("rdy1", 64'(rdy1), 64'(m_rdy[1]));
        chk("x0", 64'(x0), 64'(m_x[0]));
        chk("x1", 64'(x1), 64'(m_x[1]));
        chk("d0", 64'(d0), 64'(m_d[0]));
        chk("d1", 64'(d1), 64'(m_d[1]));
    end

    task automatic send(input logic [15:0] d, input logic [1:0] s);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        in_sel = s;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = acc_seen;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout data %0h: not accepted within 50 cycles", d);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_rdy", 64'(rdy0), 64'd0);
        chk("reset_ov", 64'(ov0), 64'd0);
        chk("reset_x", 64'(x0), 64'd0);
        chk("reset_d", 64'(d1), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_release", 64'(rdy0), 64'd1);
        out_ready = 4'hF;
        send(16'h1234, 2'd2);
        chk("first_ov", 64'(ov0), 64'h4);
        chk("first_od", 64'(od0), 64'h1234);
        @(negedge clk);
        chk("first_x", 64'(x0), 64'd1);
        for (int i = 0; i < 8; i++) send(16'(i + 1), 2'(i));
        @(negedge clk);
        chk("stream_x", 64'(x0), 64'd9);
        chk("stream_drop", 64'(d1), 64'd2);
        for (int i = 0; i < 3; i++) send(16'hD000 + 16'(i), 2'd3);
        @(negedge clk);
        chk("drop3", 64'(d1), 64'd5);
        chk("drop3_ov", 64'(ov1), 64'd0);
        for (int i = 0; i < 260; i++) send(16'(i), 2'd3);
        @(negedge clk);
        chk("drop_sat", 64'(d1), 64'd255);
        chk("nodrop_full", 64'(d0), 64'd0);
        out_ready = 4'h0;
        in_valid = 1'b1;
        in_data = 16'hAAAA;
        in_sel = 2'd1;
        @(negedge clk);
        in_data = 16'hBBBB;
        in_sel = 2'd2;
        @(negedge clk);
        chk("bp_rdy", 64'(rdy0), 64'd0);
        chk("bp_ov", 64'(ov0), 64'h2);
        in_data = 16'hCCCC;
        in_sel = 2'd3;
        repeat (3) @(negedge clk);
        chk("bp_hold_ov", 64'(ov0), 64'h2);
        chk("bp_hold_od", 64'(od0), 64'hAAAA);
        out_ready = 4'b0010;
        @(negedge clk);
        chk("bp_drain1_ov", 64'(ov0), 64'h4);
        chk("bp_drain1_od", 64'(od0), 64'hBBBB);
        chk("bp_drain1_rdy", 64'(rdy0), 64'd1);
        out_ready = 4'b0100;
        @(negedge clk);
        chk("bp_drain2_ov", 64'(ov0), 64'h8);
        chk("bp_drain2_od", 64'(od0), 64'hCCCC);
        in_valid = 1'b0;
        out_ready = 4'b1000;
        @(negedge clk);
        chk("bp_empty", 64'(ov0), 64'd0);
        chk("idle_od_hold", 64'(od0), 64'hCCCC);
        out_ready = 4'b0001;
        send(16'hD1D1, 2'd1);
        send(16'hE0E0, 2'd0);
        repeat (3) @(negedge clk);
        chk("hol_block", 64'(ov0), 64'h2);
        out_ready = 4'b0011;
        @(negedge clk);
        chk("hol_next_ov", 64'(ov0), 64'h1);
        chk("hol_next_od", 64'(od0), 64'hE0E0);
        @(negedge clk);
        chk("hol_empty", 64'(ov0), 64'd0);
        out_ready = 4'h0;
        send(16'hF1F1, 2'd1);
        send(16'hF2F2, 2'd2);
        chk("two_ov", 64'(ov0), 64'h2);
        chk("two_rdy", 64'(rdy0), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ov", 64'(ov0), 64'd0);
        chk("midrst_x", 64'(x0), 64'd0);
        chk("midrst_d", 64'(d1), 64'd0);
        chk("midrst_rdy", 64'(rdy0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy", 64'(rdy0), 64'd1);
        out_ready = 4'hF;
        send(16'hBEEF, 2'd3);
        chk("rel_ov", 64'(ov0), 64'h8);
        chk("rel_od", 64'(od0), 64'hBEEF);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid = ($urandom % 4) != 0;
            in_data = 16'($urandom);
            in_sel = 2'($urandom);
            out_ready = 4'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 4'hF;
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
